// File: rtl/io_pkg.sv
// Shared segment constants and enums for the seven-segment display controller.
package io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {ZERO, OUT, IN} mode_e;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_e;

endpackage

// File: rtl/io_display_ctrl_if.sv
// CPU-side I/O bus of the display controller: flags, data, switches and display outputs.
interface io_display_ctrl_if #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SW_BITS = 4
);

  logic                   halt;
  logic [WIDTH-1:0]       num;
  logic                   output_flag;
  logic                   input_flag;
  logic [SW_BITS-1:0]     sw;
  logic [WIDTH-1:0]       user_input;
  logic [7*DIGITS-1:0]    hex;
  logic                   busy;
  logic                   overflow;

  modport master (
    output halt, num, output_flag, input_flag, sw,
    input  user_input, hex, busy, overflow
  );

  modport slave (
    input  halt, num, output_flag, input_flag, sw,
    output user_input, hex, busy, overflow
  );

endinterface

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern; codes 10-15 show blank.
module seg7_encode
  import io_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = SEG_DIGIT[0];
      4'd1:    seg_c = SEG_DIGIT[1];
      4'd2:    seg_c = SEG_DIGIT[2];
      4'd3:    seg_c = SEG_DIGIT[3];
      4'd4:    seg_c = SEG_DIGIT[4];
      4'd5:    seg_c = SEG_DIGIT[5];
      4'd6:    seg_c = SEG_DIGIT[6];
      4'd7:    seg_c = SEG_DIGIT[7];
      4'd8:    seg_c = SEG_DIGIT[8];
      4'd9:    seg_c = SEG_DIGIT[9];
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/io_display_ctrl.sv
// Seven-segment display controller with a one-bit-per-clock double-dabble converter.
// Optional IO_DISPLAY_SIGNED_EN: OUT mode shows num as two's complement with a leading dash.
module io_display_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SW_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  io_display_ctrl_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned HEX_W = 7 * DIGITS;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  mode_e              cap_mode_q, cap_mode_d, last_mode_q, last_mode_d;
  logic [WIDTH-1:0]   bin_q, bin_d, cap_src_q, cap_src_d, last_src_q, last_src_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic               last_vld_q, last_vld_d;
  logic               sticky_q, sticky_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  mode_e              mode_c;
  logic [SW_BITS-1:0] sw_c;
  logic [WIDTH-1:0]   user_input_c, src_c, mag_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [HEX_W-1:0]   seg_c;
  logic               neg_c, ovf_c, dash_all_c;

  assign sw_c         = bus.sw;
  assign user_input_c = WIDTH'(sw_c);

  // Mode and source selection from the CPU instruction flags
  always_comb begin
    mode_c = ZERO;
    src_c  = '0;
    if (bus.output_flag && !bus.input_flag) begin
      mode_c = OUT;
      src_c  = bus.num;
    end else if (!bus.output_flag && bus.input_flag) begin
      mode_c = IN;
      src_c  = user_input_c;
    end
  end

`ifdef IO_DISPLAY_SIGNED_EN
  // Negation of the most negative value wraps to itself, which is its correct magnitude
  assign neg_c = (mode_c == OUT) && src_c[WIDTH-1];
  assign mag_c = neg_c ? (~src_c + WIDTH'(1)) : src_c;
  assign ovf_c = sticky_q | (neg_q & (bcd_q[BCD_W-1 -: 4] != 4'd0));
`else
  assign neg_c = 1'b0;
  assign mag_c = src_c;
  assign ovf_c = sticky_q;
`endif

  assign dash_all_c = (cap_mode_q == IN) && (cap_src_q == '0);

  // Add-3 correction applied to every BCD digit before each shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .digit (bcd_q[4*g +: 4]),
      .seg_c (seg_c[7*g +: 7])
    );
  end

  // Next-state and output logic; halt and ZERO mode abort any conversion
  always_comb begin
    state_d     = state_q;
    cap_mode_d  = cap_mode_q;
    last_mode_d = last_mode_q;
    bin_d       = bin_q;
    cap_src_d   = cap_src_q;
    last_src_d  = last_src_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    hex_d       = hex_q;
    last_vld_d  = last_vld_q;
    sticky_d    = sticky_q;
    neg_d       = neg_q;
    overflow_d  = overflow_q;

    if (bus.halt) begin
      state_d    = IDLE;
      hex_d      = {DIGITS{SEG_BLANK}};
      overflow_d = 1'b0;
      last_vld_d = 1'b0;
    end else if (mode_c == ZERO) begin
      state_d    = IDLE;
      hex_d      = {DIGITS{SEG_DIGIT[0]}};
      overflow_d = 1'b0;
      last_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!last_vld_q || (src_c != last_src_q) || (mode_c != last_mode_q)) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          cap_src_d  = src_c;
          cap_mode_d = mode_c;
          bin_d      = mag_c;
          neg_d      = neg_c;
          bcd_d      = '0;
          sticky_d   = 1'b0;
          cnt_d      = CNT_W'(WIDTH - 1);
          state_d    = SHIFT;
        end
        SHIFT: begin
          sticky_d = sticky_q | bcd_adj_c[BCD_W-1];
          bcd_d    = {bcd_adj_c[BCD_W-2:0], bin_q[WIDTH-1]};
          bin_d    = bin_q << 1;
          if (cnt_q == '0) begin
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dash_all_c || (neg_q && (i == DIGITS - 1))) begin
              hex_d[7*i +: 7] = SEG_DASH;
            end else begin
              hex_d[7*i +: 7] = seg_c[7*i +: 7];
            end
          end
          overflow_d  = ovf_c;
          last_src_d  = cap_src_q;
          last_mode_d = cap_mode_q;
          last_vld_d  = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_mode_q  <= ZERO;
      last_mode_q <= ZERO;
      bin_q       <= '0;
      cap_src_q   <= '0;
      last_src_q  <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hex_q       <= {HEX_W{1'b1}};
      last_vld_q  <= 1'b0;
      sticky_q    <= 1'b0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_mode_q  <= cap_mode_d;
      last_mode_q <= last_mode_d;
      bin_q       <= bin_d;
      cap_src_q   <= cap_src_d;
      last_src_q  <= last_src_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hex_q       <= hex_d;
      last_vld_q  <= last_vld_d;
      sticky_q    <= sticky_d;
      neg_q       <= neg_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.user_input = user_input_c;
  assign bus.hex        = hex_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_io_display_ctrl.sv
// Scoreboard bench for io_display_ctrl: decimal reference model, commit monitor, directed and random stimulus.
module tb_io_display_ctrl;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SW_BITS = 4;
  localparam int unsigned HEX_W   = 7 * DIGITS;
  localparam int          LAT     = WIDTH + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  io_display_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SW_BITS(SW_BITS)) bus ();

  io_display_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SW_BITS(SW_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit ign = 1'b0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  typedef struct {
    logic [HEX_W-1:0] hex;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb[$];

  bit               m_vld = 1'b0;
  int               m_mode = 0;
  logic [WIDTH-1:0] m_last = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Reference: decimal digits by division, mode 1 = OUT, mode 2 = IN
  function automatic exp_t model(input int mode, input logic [WIDTH-1:0] val, input int due);
    exp_t e;
    longint unsigned v = 64'(val);
    int nd = DIGITS;
`ifdef IO_DISPLAY_SIGNED_EN
    if (mode == 1 && val[WIDTH-1]) begin
      v  = (64'(1) << WIDTH) - v;
      nd = DIGITS - 1;
    end
`endif
    e.ovf = (v >= pow10(nd));
    for (int i = 0; i < DIGITS; i++) begin
      if (mode == 2 && v == 0) e.hex[7*i +: 7] = DASH;
      else if (i >= nd)        e.hex[7*i +: 7] = DASH;
      else                     e.hex[7*i +: 7] = seg_tab[int'((v / pow10(i)) % 10)];
    end
    e.due = due;
    return e;
  endfunction

  function automatic logic [HEX_W-1:0] fill(input logic [6:0] s);
    logic [HEX_W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = s;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode: 0/3 = ZERO (no flag / both flags), 1 = OUT, 2 = IN
  task automatic drive(input int mode, input logic [WIDTH-1:0] n, input logic [SW_BITS-1:0] s);
    bus.output_flag = (mode == 1) || (mode == 3);
    bus.input_flag  = (mode == 2) || (mode == 3);
    bus.num         = n;
    bus.sw          = s;
  endtask

  task automatic expect_conv(input int mode, input logic [WIDTH-1:0] n, input logic [SW_BITS-1:0] s,
                             input int at, output bit pushed);
    logic [WIDTH-1:0] src;
    src = (mode == 1) ? n : WIDTH'(s);
    pushed = 1'b0;
    if (!m_vld || src != m_last || mode != m_mode) begin
      sb.push_back(model(mode, src, at + LAT));
      m_vld = 1'b1; m_last = src; m_mode = mode;
      pushed = 1'b1;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && sb.size() != 0; k++) step(1);
    chk("drain_timeout", 128'(sb.size()), 128'(0));
    sb.delete();
  endtask

  task automatic apply(input int mode, input logic [WIDTH-1:0] n, input logic [SW_BITS-1:0] s);
    bit pushed;
    drive(mode, n, s);
    expect_conv(mode, n, s, cyc, pushed);
    #0;
    chk("user_input", 128'(bus.user_input), 128'(WIDTH'(s)));
    if (pushed) wait_done();
    else begin
      step(3);
      chk("no_retrigger_busy", 128'(bus.busy), 128'(0));
    end
  endtask

  // Monitor: a busy falling edge marks a commit; compare against the scoreboard head
  initial begin
    exp_t e;
    bit busy_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!(reset || ign || bus.halt) && busy_prev && !bus.busy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_commit hex=%0h overflow=%0b", bus.hex, bus.overflow);
        end else begin
          e = sb.pop_front();
          chk("commit_hex", 128'(bus.hex), 128'(e.hex));
          chk("commit_overflow", 128'(bus.overflow), 128'(e.ovf));
          chk("commit_latency", 128'(cyc), 128'(e.due));
        end
      end
      busy_prev = bus.busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int k0;
    int sel;
    logic [WIDTH-1:0] n;
    logic [SW_BITS-1:0] s;
    bit pushed;

    bus.halt = 1'b0;
    drive(0, '0, '0);
    reset = 1'b1;
    step(2);
    chk("reset_hex", 128'(bus.hex), 128'(fill(7'h7F)));
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_overflow", 128'(bus.overflow), 128'(0));
    reset = 1'b0;
    step(1);
    chk("zero_hex", 128'(bus.hex), 128'(fill(seg_tab[0])));

    apply(1, 32'd12345678, 4'd0);
    apply(1, 32'd123456789, 4'd0);
    apply(2, 32'd0, 4'b0000);
    apply(2, 32'd0, 4'b1001);
    apply(2, 32'd77, 4'b1001);
    apply(1, 32'd9, 4'b1001);
    apply(1, 32'd99999999, 4'd3);
    apply(1, 32'd100000000, 4'd3);
    apply(1, 32'hFFFF_FFFF, 4'd3);

    // ZERO after an overflowing value clears both display and flag
    drive(0, 32'd5, 4'd0);
    step(1);
    chk("zero_mode_hex", 128'(bus.hex), 128'(fill(seg_tab[0])));
    chk("zero_mode_overflow", 128'(bus.overflow), 128'(0));
    m_vld = 1'b0;
    apply(1, 32'd123456789, 4'd0);

    // halt during the 10th shift, then release with num=7
    ign = 1'b1;
    drive(1, 32'd555, 4'd0);
    step(11);
    chk("busy_mid_shift", 128'(bus.busy), 128'(1));
    bus.halt = 1'b1;
    step(1);
    chk("halt_hex", 128'(bus.hex), 128'(fill(7'h7F)));
    chk("halt_busy", 128'(bus.busy), 128'(0));
    chk("halt_overflow", 128'(bus.overflow), 128'(0));
    step(3);
    chk("halt_hold_hex", 128'(bus.hex), 128'(fill(7'h7F)));
    ign = 1'b0;
    m_vld = 1'b0;
    bus.halt = 1'b0;
    apply(1, 32'd7, 4'd0);

    // asynchronous reset mid-shift
    apply(1, 32'd4000000000, 4'd0);
    ign = 1'b1;
    drive(1, 32'd87654321, 4'd0);
    step(10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset_hex", 128'(bus.hex), 128'(fill(7'h7F)));
    chk("async_reset_busy", 128'(bus.busy), 128'(0));
    chk("async_reset_overflow", 128'(bus.overflow), 128'(0));
    step(1);
    reset = 1'b0;
    ign = 1'b0;
    m_vld = 1'b0;
    expect_conv(1, 32'd87654321, 4'd0, cyc, pushed);
    wait_done();

    // both flags set mid-conversion aborts with no later commit
    ign = 1'b1;
    drive(1, 32'd1111, 4'd0);
    step(15);
    drive(3, 32'd1111, 4'd0);
    step(1);
    chk("abort_zero_hex", 128'(bus.hex), 128'(fill(seg_tab[0])));
    chk("abort_zero_busy", 128'(bus.busy), 128'(0));
    step(40);
    chk("abort_zero_no_commit", 128'(bus.busy), 128'(0));
    ign = 1'b0;
    m_vld = 1'b0;

    // OUT -> IN mid-conversion: first conversion commits, then reconverts
    drive(1, 32'd2468, 4'd5);
    k0 = cyc;
    expect_conv(1, 32'd2468, 4'd5, k0, pushed);
    step(10);
    drive(2, 32'd2468, 4'd5);
    sb.push_back(model(2, 32'd5, k0 + 2 * LAT));
    m_last = 32'd5; m_mode = 2;
    wait_done();

`ifdef IO_DISPLAY_SIGNED_EN
    apply(1, -32'sd42, 4'd0);
    apply(1, 32'h8000_0000, 4'd0);
`endif

    n = '0;
    s = '0;
    for (int it = 0; it < 25; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: n = WIDTH'($urandom);
        1: n = WIDTH'($urandom_range(0, 99999999));
        2: ;
        default: n = WIDTH'(pow10(DIGITS) + longint'($urandom_range(0, 2)) - 1);
      endcase
      if ($urandom_range(0, 3) != 0) s = SW_BITS'($urandom_range(0, 15));
      apply(int'($urandom_range(1, 2)), n, s);
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_display_ctrl.md
# io_display_ctrl

Parametrised seven-segment display controller for the processor I/O path. It converts a binary value to decimal with a sequential shift-add-3 (double-dabble) engine, one bit per clock, instead of chained divide/modulo logic. It drives DIGITS active-low digit outputs, mirrors the user switches as an input word, and flags values too large for the display. It sits between the CPU I/O instruction flags and the board HEX displays.

## Interface
- DIGITS, 8: number of seven-segment digits (1..10).
- WIDTH, 32: width of `num` and `user_input`.
- SW_BITS, 4: number of switch bits used as user input (≤ WIDTH).
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- halt  in  1  CPU halted; blanks the display synchronously.
- num  in  WIDTH  value to display in output mode.
- output_flag  in  1  CPU output instruction active.
- input_flag  in  1  CPU input instruction active.
- sw  in  SW_BITS  board switches.
- user_input  out  WIDTH  combinational, `sw` zero-extended to WIDTH.
- hex  out  7*DIGITS  `hex[7*i +: 7]` is digit i (i=0 least significant); bit6=g … bit0=a; active-low; registered.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value ≥ 10^DIGITS; registered.

## Operation
- Mode, from flags every cycle: OUT = output_flag & !input_flag (source `num`); IN = !output_flag & input_flag (source `user_input`); ZERO = otherwise.
- Priority: reset > halt > mode.
- halt: hex ← all 7'h7F, busy ← 0, overflow ← 0, FSM → IDLE (abort).
- ZERO: hex ← every digit 7'b1000000, overflow ← 0, FSM → IDLE (abort).
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE → LOAD when mode is OUT/IN and (source ≠ last committed value, or mode ≠ last committed mode, or no commit since reset/halt/ZERO).
  - LOAD: capture source into shift register, clear 4*DIGITS BCD register and sticky overflow, counter ← WIDTH−1.
  - SHIFT: for each BCD digit ≥ 5 add 3, then shift {bcd, bin} left by one; bit shifted out of the top digit ORs into sticky overflow. Decrement counter; after WIDTH shifts → COMMIT.
  - COMMIT: encode each BCD digit into hex, overflow ← sticky, record committed value and mode → IDLE.
- Truncation yields value mod 10^DIGITS; all DIGITS digits shown, leading zeros included.
- IN mode with captured value 0: COMMIT writes dash 7'b0111111 to every digit instead of zeros.
- Source changes during LOAD..COMMIT are ignored; the IDLE comparison re-triggers afterwards.
- Mode change OUT↔IN mid-conversion: current conversion completes and commits, then reconverts.
- Encoding 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; BCD values 10–15 never occur; encode as blank.

## Timing
- Reset values: hex all 1s, busy 0, overflow 0, FSM IDLE, no committed value.
- Latency from source/mode change at edge N to hex update: visible after edge N+WIDTH+3 (IDLE detect 1, LOAD 1, SHIFT WIDTH, COMMIT 1).
- busy high from LOAD through COMMIT inclusive.
- halt/ZERO effect visible after the next edge; aborts mid-SHIFT without a partial commit.
- Asynchronous reset mid-conversion: immediate return to reset values.

## Configuration
- IO_DISPLAY_SIGNED_EN defined: OUT mode treats `num` as two's complement; negative values convert the magnitude (2^(WIDTH−1) handled correctly); digit DIGITS−1 shows 7'b0111111 for negative and the magnitude occupies the low DIGITS−1 digits; overflow when magnitude ≥ 10^(DIGITS−1). IN mode stays unsigned.
- Undefined: all values unsigned; behaviour exactly as above.

## Structure
- Package `io_pkg`: segment constants SEG_BLANK (7'h7F), SEG_DASH (7'b0111111), SEG_DIGIT[0:9]; mode enum (ZERO, OUT, IN); FSM state enum.
- Sub-module `seg7_encode`: combinational 4-bit digit → 7-bit active-low segments, instantiated DIGITS times at COMMIT.

## Test plan
- Assert reset mid-SHIFT → hex all 7'h7F, busy 0, overflow 0 immediately.
- OUT, num=12345678 → after 35 edges hex digit0=0000000 (8), digit7=1111001 (1), overflow 0, busy low.
- OUT, num=123456789 → digits show 23456789, overflow 1.
- IN, sw=4'b0000 → all digits 0111111; sw=4'b1001 → digit0=0010000, digits1–7=1000000.
- halt asserted at 10th SHIFT cycle → blank next edge, busy 0; halt released with num=7 → digit0=1111000 after 35 edges.
- IO_DISPLAY_SIGNED_EN, num=−42 → digit7=0111111, digit1=0011001, digit0=0100100, digits2–6=1000000.
